// File: rtl/control_puertas.sv
// Elevator car door controller: detects floor arrival, runs the
// open/hold/close cycle and holds ALGORITMO via esperar until closed.
module control_puertas #(
  parameter int T_ABIERTA = 1000,
  parameter int T_MOV     = 200,
  parameter int ANCHO_CNT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] motor,
  input  logic       boton_abrir,
  input  logic       boton_cerrar,
  input  logic       obstruccion,
  input  logic       fin_abierta,
  input  logic       fin_cerrada,
  output logic       esperar,
  output logic [1:0] puerta,
  output logic       falla
);

  typedef enum logic [2:0] {
    CERRADA,
    ABRIENDO,
    ABIERTA,
    CERRANDO,
    FALLA
  } estado_t;

  localparam logic [ANCHO_CNT-1:0] CNT_ABI = ANCHO_CNT'(T_ABIERTA - 1);
  localparam logic [ANCHO_CNT-1:0] CNT_MOV = ANCHO_CNT'(T_MOV - 1);

  estado_t              state_q, state_d;
  logic [ANCHO_CNT-1:0] cnt_q, cnt_d;
  logic [1:0]           motor_prev_q, motor_prev_d;

  logic parado;
  logic llegada;
  logic cnt_cero;

  assign parado   = (motor == 2'b00);
  assign llegada  = (motor_prev_q != 2'b00) && parado;
  assign cnt_cero = (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_cero ? cnt_q : cnt_q - 1'b1;
    motor_prev_d = motor;
    unique case (state_q)
      CERRADA: begin
        if (parado && (llegada || boton_abrir)) begin
          state_d = ABRIENDO;
          cnt_d   = CNT_MOV;
        end
      end
      ABRIENDO: begin
        if (fin_abierta) begin
          state_d = ABIERTA;
          cnt_d   = CNT_ABI;
        end else if (cnt_cero) begin
          state_d = FALLA;
        end
      end
      ABIERTA: begin
        if (boton_abrir || obstruccion) begin
          cnt_d = CNT_ABI;
        end else if (boton_cerrar || cnt_cero) begin
          state_d = CERRANDO;
          cnt_d   = CNT_MOV;
        end
      end
      CERRANDO: begin
        // Reopening wins over the closed switch so a trapped
        // passenger is never squeezed at the last moment.
        if (obstruccion || boton_abrir) begin
          state_d = ABRIENDO;
          cnt_d   = CNT_MOV;
        end else if (fin_cerrada) begin
          state_d = CERRADA;
        end else if (cnt_cero) begin
          state_d = FALLA;
        end
      end
      FALLA: ;
      default: state_d = FALLA;
    endcase
    if (state_q != FALLA) begin
      if ((fin_abierta && fin_cerrada) ||
          (state_q != CERRADA && !parado)) begin
        state_d = FALLA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CERRANDO;
      cnt_q        <= CNT_MOV;
      motor_prev_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      motor_prev_q <= motor_prev_d;
    end
  end

  always_comb begin
    esperar = (state_q != CERRADA);
    falla   = (state_q == FALLA);
    puerta  = 2'b00;
    unique case (state_q)
      ABRIENDO: puerta = 2'b01;
      CERRANDO: puerta = 2'b10;
      default:  puerta = 2'b00;
    endcase
  end

endmodule
